point_raster_writer: RTL and testbench

POINT_RASTER_WRITER -- requirements
Module: point_raster_writer

---
 rtl/point_raster_writer_pkg.sv | 29 ++
 rtl/point_raster_writer_fp16_to_int.sv | 29 ++
 rtl/point_raster_writer.sv | 182 ++++++++++++++++++
 tb/tb_point_raster_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/point_raster_writer_pkg.sv
// Shared definitions for the point raster writer: register map, STATUS bits,
// FSM encoding and default framebuffer geometry.
package point_raster_writer_pkg;

    localparam int unsigned DEFAULT_SCREEN_W = 320;
    localparam int unsigned DEFAULT_SCREEN_H = 240;

    localparam logic [2:0] OFF_PX     = 3'd0;
    localparam logic [2:0] OFF_PY     = 3'd1;
    localparam logic [2:0] OFF_COLOR  = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_PIXX   = 3'd5;
    localparam logic [2:0] OFF_PIXY   = 3'd6;
    localparam logic [2:0] OFF_RSVD   = 3'd7;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_CLIPPED = 1;
    localparam int unsigned ST_DONE    = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_X = 3'd1,
        CONV_Y = 3'd2,
        CLIP   = 3'd3,
        WRITE  = 3'd4
    } state_t;

endpackage

// File: rtl/point_raster_writer_fp16_to_int.sv
// Combinational IEEE half-precision to signed integer conversion, truncating
// toward zero; exponents of 30 and above (incl. Inf/NaN) raise outOfRange.
module fp16_to_int (
    input  logic [15:0]        fpIn,
    output logic signed [15:0] intOut,
    output logic               outOfRange
);

    logic [4:0]  expo;
    logic [25:0] shifted;
    logic [15:0] mag;

    always_comb begin
        expo       = fpIn[14:10];
        shifted    = '0;
        mag        = '0;
        intOut     = '0;
        outOfRange = 1'b0;
        if (expo >= 5'd30) begin
            outOfRange = 1'b1;
        end else if (expo >= 5'd15) begin
            // Dropping the low 10 bits after the shift truncates the fraction.
            shifted = {15'd0, 1'b1, fpIn[9:0]} << (expo - 5'd15);
            mag     = shifted[25:10];
            intOut  = fpIn[15] ? (~mag + 16'd1) : mag;
        end
    end

endmodule

// File: rtl/point_raster_writer.sv
// Memory-mapped point plotter: converts an fp16 projected (x,y) to screen
// coordinates, clips, and issues one framebuffer pixel write per start.
module point_raster_writer
    import point_raster_writer_pkg::*;
#(
    parameter int unsigned BASE     = 0,
    parameter int unsigned SCREEN_W = DEFAULT_SCREEN_W,
    parameter int unsigned SCREEN_H = DEFAULT_SCREEN_H
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    inout  logic [15:0] BUS,
    input  logic [31:0] address,
    input  logic        writeEn,
    input  logic        outputEn,
    output logic        fb_req,
    output logic [16:0] fb_addr,
    output logic [15:0] fb_data,
    input  logic        fb_ack
);

    localparam logic signed [16:0] HALF_W = 17'(SCREEN_W / 2);
    localparam logic signed [16:0] HALF_H = 17'(SCREEN_H / 2);
    localparam logic signed [16:0] LIM_W  = 17'(SCREEN_W);
    localparam logic signed [16:0] LIM_H  = 17'(SCREEN_H);
    localparam logic [16:0]        W_U    = 17'(SCREEN_W);

    state_t state, nextState;

    logic [31:0] offsetFull;
    logic [2:0]  regSel;
    logic        cs;
    logic        startReq;
    logic        regWrite;

    logic [15:0] pxReg, pyReg, colorReg, pixX, pixY, readBuf, statusWord;
    logic        done, clipped;

    logic signed [16:0] xPos, yPos;
    logic               xOor, yOor;
    logic               clipHit;
    logic [16:0]        pixAddr;

    logic [15:0]        convIn;
    logic signed [15:0] convVal;
    logic               convOor;

    // Addresses below BASE wrap to large offsets, so one compare covers both bounds.
    assign offsetFull = address - 32'(BASE);
    assign cs         = (offsetFull < 32'd8);
    assign regSel     = offsetFull[2:0];
    assign regWrite   = cs && writeEn && (state == IDLE);
    assign startReq   = regWrite && (regSel == OFF_CTRL);

    assign BUS = (cs && outputEn && RESET_N) ? readBuf : 'z;

    assign convIn = (state == CONV_Y) ? pyReg : pxReg;

    fp16_to_int u_conv (
        .fpIn      (convIn),
        .intOut    (convVal),
        .outOfRange(convOor)
    );

    assign clipHit = xOor || yOor || xPos[16] || (xPos >= LIM_W) ||
                     yPos[16] || (yPos >= LIM_H);

    always_comb begin
        statusWord           = '0;
        statusWord[ST_BUSY]    = (state != IDLE);
        statusWord[ST_CLIPPED] = clipped;
        statusWord[ST_DONE]    = done;
    end

    // Constant-coefficient y*SCREEN_W as a sum of shifted copies of y.
    always_comb begin
        pixAddr = '0;
        for (int unsigned i = 0; i < 17; i++) begin
            if (W_U[i]) begin
                pixAddr = pixAddr + (yPos[16:0] << i);
            end
        end
        pixAddr = pixAddr + xPos[16:0];
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startReq) nextState = CONV_X;
            CONV_X:  nextState = CONV_Y;
            CONV_Y:  nextState = CLIP;
            CLIP:    nextState = clipHit ? IDLE : WRITE;
            WRITE:   if (fb_ack) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pxReg    <= '0;
            pyReg    <= '0;
            colorReg <= '0;
            pixX     <= '0;
            pixY     <= '0;
            readBuf  <= '0;
            done     <= 1'b0;
            clipped  <= 1'b0;
            xPos     <= '0;
            yPos     <= '0;
            xOor     <= 1'b0;
            yOor     <= 1'b0;
            fb_req   <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            if (cs) begin
                case (regSel)
                    OFF_PX:     readBuf <= pxReg;
                    OFF_PY:     readBuf <= pyReg;
                    OFF_COLOR:  readBuf <= colorReg;
                    OFF_STATUS: readBuf <= statusWord;
                    OFF_PIXX:   readBuf <= pixX;
                    OFF_PIXY:   readBuf <= pixY;
                    default:    readBuf <= '0;
                endcase
            end

            if (regWrite) begin
                case (regSel)
                    OFF_PX:    pxReg    <= BUS;
                    OFF_PY:    pyReg    <= BUS;
                    OFF_COLOR: colorReg <= BUS;
                    default:   ;
                endcase
            end

            if (startReq) begin
                done    <= 1'b0;
                clipped <= 1'b0;
            end

            case (state)
                CONV_X: begin
                    xPos <= HALF_W + {convVal[15], convVal};
                    xOor <= convOor;
                end
                CONV_Y: begin
                    yPos <= HALF_H - {convVal[15], convVal};
                    yOor <= convOor;
                end
                CLIP: begin
                    pixX <= xPos[15:0];
                    pixY <= yPos[15:0];
                    if (clipHit) begin
                        done    <= 1'b1;
                        clipped <= 1'b1;
                    end else begin
                        fb_req  <= 1'b1;
                        fb_addr <= pixAddr;
                        fb_data <= colorReg;
                    end
                end
                WRITE: begin
                    if (fb_ack) begin
                        fb_req <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_raster_writer.sv
// Scoreboard bench for point_raster_writer: stimulus pushes expected pixel
// writes from a real-arithmetic model, a monitor pops them on each fb_req.
module tb_point_raster_writer;

    localparam logic [31:0] TB_BASE  = 32'h100;
    localparam int          SW       = 320;
    localparam int          SH       = 240;
    localparam logic [31:0] IDLE_ADR = 32'h40;

    logic        CLOCK_50;
    logic        RESET_N;
    tri1  [15:0] BUS;
    logic [31:0] address;
    logic        writeEn;
    logic        outputEn;
    logic        fb_req;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_ack;

    logic [15:0] cpuDrive;
    logic        cpuDriveEn;

    assign BUS = cpuDriveEn ? cpuDrive : 'z;

    point_raster_writer #(
        .BASE    (TB_BASE),
        .SCREEN_W(SW),
        .SCREEN_H(SH)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .BUS     (BUS),
        .address (address),
        .writeEn (writeEn),
        .outputEn(outputEn),
        .fb_req  (fb_req),
        .fb_addr (fb_addr),
        .fb_data (fb_data),
        .fb_ack  (fb_ack)
    );

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } fbTxn_t;

    fbTxn_t expQ[$];
    int     checks   = 0;
    int     failures = 0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each new fb_req consumes one expectation; held values checked every cycle.
    bit     inTxn = 1'b0;
    fbTxn_t held;
    always @(negedge CLOCK_50) begin
        if (fb_req) begin
            if (!inTxn) begin
                inTxn = 1'b1;
                if (expQ.size() == 0) begin
                    check("fbReqUnexpected", 32'(fb_req), 32'd0);
                    held.addr = fb_addr;
                    held.data = fb_data;
                end else begin
                    held = expQ.pop_front();
                    check("fbAddr", 32'(fb_addr), 32'(held.addr));
                    check("fbData", 32'(fb_data), 32'(held.data));
                end
            end else begin
                check("fbAddrStable", 32'(fb_addr), 32'(held.addr));
                check("fbDataStable", 32'(fb_data), 32'(held.data));
            end
        end else begin
            inTxn = 1'b0;
        end
    end

    // Reference: value = (1 + mant/1024) * 2^(e-15), truncated toward zero.
    function automatic void refConv(input logic [15:0] f, output int v, output bit oor);
        int  e;
        real m;
        e   = int'(f[14:10]);
        v   = 0;
        oor = 1'b0;
        if (e >= 30) begin
            oor = 1'b1;
        end else if (e >= 15) begin
            m = 1.0 + real'(f[9:0]) / 1024.0;
            for (int k = 15; k < e; k++) m = m * 2.0;
            v = $rtoi(m);
            if (f[15]) v = -v;
        end
    endfunction

    task automatic cpuWriteAbs(input logic [31:0] adr, input logic [15:0] data);
        @(negedge CLOCK_50);
        address    = adr;
        writeEn    = 1'b1;
        cpuDrive   = data;
        cpuDriveEn = 1'b1;
        @(negedge CLOCK_50);
        writeEn    = 1'b0;
        cpuDriveEn = 1'b0;
        address    = IDLE_ADR;
    endtask

    task automatic cpuWrite(input logic [2:0] off, input logic [15:0] data);
        cpuWriteAbs(TB_BASE + 32'(off), data);
    endtask

    task automatic cpuRead(input logic [2:0] off, output logic [15:0] data);
        @(negedge CLOCK_50);
        address  = TB_BASE + 32'(off);
        outputEn = 1'b1;
        @(negedge CLOCK_50);
        data     = BUS;
        outputEn = 1'b0;
        address  = IDLE_ADR;
    endtask

    task automatic readCheck(input string name, input logic [2:0] off, input logic [15:0] exp);
        logic [15:0] v;
        cpuRead(off, v);
        check(name, 32'(v), 32'(exp));
    endtask

    task automatic runStart(input logic [15:0] px, input logic [15:0] py,
                            input logic [15:0] color, input int ackDelay, input bit midWrites);
        int vx, vy, x, y;
        bit ox, oy, clip;
        int remain;
        cpuWrite(3'd0, px);
        cpuWrite(3'd1, py);
        cpuWrite(3'd2, color);
        refConv(px, vx, ox);
        refConv(py, vy, oy);
        x    = SW / 2 + vx;
        y    = SH / 2 - vy;
        clip = ox || oy || (x < 0) || (x >= SW) || (y < 0) || (y >= SH);
        if (!clip) expQ.push_back('{addr: 17'(y * SW + x), data: color});
        cpuWrite(3'd3, 16'($urandom));
        check("fbReqConvX", 32'(fb_req), 32'd0);
        repeat (2) begin
            @(negedge CLOCK_50);
            check("fbReqConv", 32'(fb_req), 32'd0);
        end
        @(negedge CLOCK_50);
        check("fbReqAtN4", 32'(fb_req), 32'(!clip));
        if (clip) begin
            repeat (3) begin
                @(negedge CLOCK_50);
                check("fbReqClipped", 32'(fb_req), 32'd0);
            end
        end else begin
            remain = ackDelay;
            if (midWrites) begin
                cpuWrite(3'd0, ~px);
                cpuWrite(3'd3, 16'h1);
                remain = ackDelay - 4;
            end
            repeat (remain) @(negedge CLOCK_50);
            fb_ack = 1'b1;
            @(negedge CLOCK_50);
            fb_ack = 1'b0;
            check("fbReqDrop", 32'(fb_req), 32'd0);
        end
        readCheck("status", 3'd4, clip ? 16'h0006 : 16'h0004);
        if (!ox && !oy) begin
            readCheck("pixX", 3'd5, 16'(x));
            readCheck("pixY", 3'd6, 16'(y));
        end
        if (midWrites) readCheck("pxIgnoredBusy", 3'd0, px);
    endtask

    function automatic logic [15:0] randFp();
        logic [4:0] e;
        e = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(13, 22));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    initial begin
        logic [15:0] v;
        RESET_N    = 1'b0;
        address    = IDLE_ADR;
        writeEn    = 1'b0;
        outputEn   = 1'b0;
        fb_ack     = 1'b0;
        cpuDrive   = '0;
        cpuDriveEn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rstFbReq", 32'(fb_req), 32'd0);
        check("rstFbAddr", 32'(fb_addr), 32'd0);
        check("rstFbData", 32'(fb_data), 32'd0);
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) readCheck("rstReg", 3'(i), 16'h0);

        runStart(16'h4900, 16'hCD20, 16'hF800, 2, 1'b0);
        readCheck("colorRead", 3'd2, 16'hF800);
        readCheck("ctrlRead", 3'd3, 16'h0);
        readCheck("rsvdRead", 3'd7, 16'h0);
        runStart(16'h5A40, 16'h0000, 16'h1234, 0, 1'b0);
        runStart(16'h7C00, 16'h0000, 16'h5555, 0, 1'b0);
        runStart(16'h3800, 16'h0000, 16'h07E0, 1, 1'b0);
        runStart(16'h4900, 16'hCD20, 16'h001F, 5, 1'b1);

        @(negedge CLOCK_50);
        address  = TB_BASE + 32'd8;
        outputEn = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check("busHiZAbove", 32'(BUS), 32'hFFFF);
        address = TB_BASE - 32'd1;
        @(negedge CLOCK_50);
        check("busHiZBelow", 32'(BUS), 32'hFFFF);
        outputEn = 1'b0;
        address  = IDLE_ADR;
        cpuWriteAbs(TB_BASE + 32'd8, 16'hBEEF);
        readCheck("pxOutsideWrite", 3'd0, 16'h4900);

        for (int n = 0; n < 40; n++)
            runStart(randFp(), randFp(), 16'($urandom), $urandom_range(0, 3), 1'b0);

        cpuWrite(3'd0, 16'h3800);
        cpuWrite(3'd1, 16'h0000);
        cpuWrite(3'd2, 16'hABCD);
        expQ.push_back('{addr: 17'd38560, data: 16'hABCD});
        cpuWrite(3'd3, 16'h1);
        repeat (3) @(negedge CLOCK_50);
        check("fbReqBeforeRst", 32'(fb_req), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("fbReqAsyncRst", 32'(fb_req), 32'd0);
        check("fbAddrAsyncRst", 32'(fb_addr), 32'd0);
        check("fbDataAsyncRst", 32'(fb_data), 32'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        fb_ack = 1'b1;
        @(negedge CLOCK_50);
        fb_ack = 1'b0;
        repeat (2) begin
            @(negedge CLOCK_50);
            check("fbReqAfterRst", 32'(fb_req), 32'd0);
        end
        for (int i = 0; i < 8; i++) readCheck("postRstReg", 3'(i), 16'h0);

        check("expQEmpty", 32'(expQ.size()), 32'd0);
        cpuRead(3'd4, v);
        check("finalStatus", 32'(v), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
